shift_pipe: RTL
===============

SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have derived parameter SHAMT_W, default $clog2(WIDTH), shift-amount width; it SHALL equal the stage count.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted this cycle when high with in_valid.
REQ-007 SHALL have port in_data  input  WIDTH  operand.
REQ-008 SHALL have port in_shamt  input  SHAMT_W  shift amount.
REQ-009 SHALL have port in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_data  output  WIDTH  shifted result.

Function
REQ-013 SHALL implement SHAMT_W registered stages; stage k (k = 0..SHAMT_W-1) shifts by 2^k when bit k of the carried shamt is 1, else passes data unchanged.
REQ-014 Each stage register SHALL hold valid, data, shamt and mode.
REQ-015 Stage fill: SLL fills with zero; SRL fills with zero; SRA fills with the operand's original MSB at every stage; ROL wraps the bits shifted out into the vacated low bits.
REQ-016 Latency SHALL be exactly SHAMT_W cycles from acceptance to out_valid with no stall (5 at WIDTH=32).
REQ-017 Global advance enable SHALL be adv = ~out_valid | out_ready; all stages SHALL shift forward only when adv is 1.
REQ-018 in_ready SHALL equal adv, combinationally; no combinational path from in_valid to in_ready.
REQ-019 When adv=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 0.
REQ-020 When adv=0, every stage SHALL hold its contents; out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-022 out_valid/out_data SHALL be the last stage's valid/data; out_data is don't-care when out_valid=0.
REQ-023 shamt=0 SHALL return in_data unchanged for all modes.
REQ-024 The shamt range SHALL be limited to 0..WIDTH-1; no wider shift is expressible.
REQ-025 Simultaneous pop and push (out_valid & out_ready & in_valid) SHALL complete both in the same cycle without loss or duplication.

Reset
REQ-026 On reset=1 at a clock edge, all stage valid bits SHALL clear; out_valid SHALL be 0 the following cycle.
REQ-027 Reset mid-operation SHALL discard all in-flight requests; none SHALL appear afterwards.
REQ-028 Data/shamt/mode registers need not be reset.
REQ-029 in_ready SHALL be 1 during and after reset, because out_valid is 0.

Structure
REQ-030 A shared package shift_pkg SHALL hold the mode encodings SLL/SRL/SRA/ROL and the 2-bit mode type.
REQ-031 A sub-module shift_stage SHALL be parametrised by WIDTH and stage index K, holding one stage's combinational shift and its register slice; shift_pipe SHALL instantiate it SHAMT_W times via generate.

Verification
REQ-032 SLL, 0x000000AB, shamt 8, out_ready=1 -> out_data 0x0000AB00 with out_valid exactly 5 cycles after acceptance.
REQ-033 SRA 0x80000000 shamt 4 -> 0xF8000000; SRL same operand -> 0x08000000; SRA shamt 31 -> 0xFFFFFFFF.
REQ-034 ROL 0x80000001 shamt 1 -> 0x00000003; ROL any value shamt 0 -> unchanged.
REQ-035 Stream 8 back-to-back requests, out_ready=0 for 3 cycles mid-stream -> in_ready=0 during stall, out_data stable, all 8 results in order, none lost or duplicated.
REQ-036 Assert reset for 1 cycle with 3 requests in flight -> out_valid=0 for the next 5 cycles; the first post-reset request returns after 5 cycles.
REQ-037 Random mode/shamt/data at WIDTH=32 and WIDTH=16 vs. a reference model with random out_ready -> zero mismatches over 10k transactions.

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared mode encodings for the pipelined barrel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } mode_t;

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage
// Description : One barrel-shifter stage: conditional shift by 2^K and its
//               pipeline register slice (valid, data, shamt, mode).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int K       = 0,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_adv,
  input  logic               i_valid,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  mode_t              i_mode,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_data,
  output logic [SHAMT_W-1:0] o_shamt,
  output mode_t              o_mode
);

  localparam int c_DIST = 1 << K;

  logic [WIDTH-1:0] w_shifted;

  // An arithmetic shift never changes the MSB, so the current MSB is always
  // the operand's original sign bit.
  always_comb begin
    w_shifted = i_data;
    if (i_shamt[K]) begin
      case (i_mode)
        MODE_SLL: w_shifted = i_data << c_DIST;
        MODE_SRL: w_shifted = i_data >> c_DIST;
        MODE_SRA: w_shifted = $signed(i_data) >>> c_DIST;
        MODE_ROL: w_shifted = (i_data << c_DIST) | (i_data >> (WIDTH - c_DIST));
        default:  w_shifted = i_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
    end else if (i_adv) begin
      o_valid <= i_valid;
    end
  end

  // Payload is never reset; it is only meaningful alongside o_valid.
  always_ff @(posedge clk) begin
    if (i_adv) begin
      o_data  <= w_shifted;
      o_shamt <= i_shamt;
      o_mode  <= i_mode;
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shift_pipe
// Description : Pipelined barrel shifter (SLL/SRL/SRA/ROL), one stage per
//               shift-amount bit, with a single global advance enable.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  // Index 0 is the request port; index k+1 is the register of stage k.
  logic               w_valid [0:SHAMT_W];
  logic [WIDTH-1:0]   w_data  [0:SHAMT_W];
  logic [SHAMT_W-1:0] w_shamt [0:SHAMT_W];
  mode_t              w_mode  [0:SHAMT_W];
  logic               w_adv;
  logic               w_unused;

  // The whole pipe moves in lockstep, so in_ready depends only on the output side.
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_shamt[0] = in_shamt;
  assign w_mode[0]  = mode_t'(in_mode);

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .WIDTH   (WIDTH),
      .K       (k),
      .SHAMT_W (SHAMT_W)
    ) u_stage (
      .clk     (clock),
      .rst     (reset),
      .i_adv   (w_adv),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .i_shamt (w_shamt[k]),
      .i_mode  (w_mode[k]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1]),
      .o_shamt (w_shamt[k+1]),
      .o_mode  (w_mode[k+1])
    );
  end

  assign out_valid = w_valid[SHAMT_W];
  assign out_data  = w_data[SHAMT_W];

  assign w_unused = ^{w_shamt[SHAMT_W], w_mode[SHAMT_W]};

endmodule
`default_nettype wire
